mem_responder: RTL and testbench

Single-port memory responder serving the pipeline's fetch or data port; one instance sits behind `imem_*` and one behind `dmem_*` in the pipelined RV32I core. It accepts one masked word request per cycle and returns a registered one-cycle `resp` pulse exactly `LATENCY` cycles later, in request order. Writes commit on acceptance. An optional `flush` kills in-flight responses, for example fetches on a mispredicted path.

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_resp_pipe.sv | 33 +++
 rtl/mem_responder.sv | 78 +++++++
 tb/tb_mem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared request/response types and helpers for the pipeline memory responders.
package mem_responder_pkg;

  localparam logic [31:0] MEM_BASE_ADDR = 32'h1ECE_B000;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
    logic        err;
  } mem_resp_t;

  // Widen a 4-bit byte-enable into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-length delay line of responses; flush invalidates every entry still
// inside the line while the entry being loaded this edge survives.
module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  mem_resp_t entry,
  output mem_resp_t oldest
);

  mem_resp_t stages [LATENCY];

  // Killed entries are zeroed whole so rdata/err read 0 whenever resp is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= entry;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= flush ? '0 : stages[i-1];
      end
    end
  end

  assign oldest = stages[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory with byte masks, address checking and a fixed-latency
// in-order response path.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          LATENCY     = 2,
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [3:0]  rmask,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        resp,
  output logic        err
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  mem_req_t    req;
  mem_resp_t   entry;
  mem_resp_t   oldest;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] offset;
  logic [IDX_W-1:0] idx;
  logic        req_valid;
  logic        bad;
  logic        ok;

  assign req = '{addr: addr, rmask: rmask, wmask: wmask, wdata: wdata};

  // Addresses below the base wrap to large offsets and fail the span check.
  assign offset    = req.addr - BASE_ADDR;
  assign idx       = offset[IDX_W+1:2];
  assign bad       = (req.addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
  assign req_valid = |(req.rmask | req.wmask);
  assign ok        = req_valid && !bad;

  // Read samples pre-write contents, so read+write returns the old word.
  always_comb begin
    entry      = '0;
    entry.resp = req_valid;
    entry.err  = req_valid && bad;
    if (ok) begin
      entry.rdata = mem[idx] & lane_mask(req.rmask);
    end
  end

  always_ff @(posedge clk) begin
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        if (req.wmask[i]) begin
          mem[idx][8*i +: 8] <= req.wdata[8*i +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .entry  (entry),
    .oldest (oldest)
  );

  assign rdata = oldest.rdata;
  assign resp  = oldest.resp;
  assign err   = oldest.err;

endmodule

// File: tb/tb_mem_responder.sv
// Drives four responders (latencies 1, 2, 3, 5) with shared stimulus and checks
// each against a cycle-indexed reference of requests, flushes and memory.
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h1ECE_B000;
  localparam int          WORDS = 64;
  localparam int          NCYC  = 2048;
  localparam int          NDUT  = 4;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  rmask = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;

  logic [31:0] rdata_l [NDUT];
  logic        resp_l  [NDUT];
  logic        err_l   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(
      .LATENCY     (lat_of(g)),
      .DEPTH_WORDS (WORDS),
      .BASE_ADDR   (BASE)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .rmask (rmask),
      .wmask (wmask),
      .wdata (wdata),
      .flush (flush),
      .rdata (rdata_l[g]),
      .resp  (resp_l[g]),
      .err   (err_l[g])
    );
  end

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference: per-cycle request outcome plus flush history and a word array.
  bit          hv   [NCYC];
  bit          herr [NCYC];
  bit          hfl  [NCYC];
  logic [31:0] hrd  [NCYC];
  logic [31:0] mem_m [WORDS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // A flush at edge m kills requests still internal: those accepted at edges m-L+1..m-1.
  function automatic bit killed(input int s, input int lat);
    for (int m = s + 1; m <= s + lat - 1; m++) begin
      if (hfl[m]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    for (int g = 0; g < NDUT; g++) begin
      int s;
      logic [33:0] exp;
      s   = cyc - lat_of(g);
      exp = '0;
      if (s >= 0 && hv[s] && !killed(s, lat_of(g))) exp = {1'b1, herr[s], hrd[s]};
      check($sformatf("lat%0d_out", lat_of(g)), {resp_l[g], err_l[g], rdata_l[g]}, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input logic fl);
    logic [31:0] off;
    logic [31:0] lanes;
    bit v, bad;
    int w;
    @(negedge clk);
    check_outputs();
    addr = a; rmask = rm; wmask = wm; wdata = wd; flush = fl;
    off = a - BASE;
    bad = (a[1:0] != 2'b00) || (off >= 32'(WORDS * 4));
    v   = (rm != 4'h0) || (wm != 4'h0);
    w   = int'(off[7:2]);
    lanes = '0;
    for (int b = 0; b < 4; b++) if (rm[b]) lanes[8*b +: 8] = 8'hFF;
    hv[cyc]   = v;
    herr[cyc] = v && bad;
    hfl[cyc]  = fl;
    hrd[cyc]  = (v && !bad) ? (mem_m[w] & lanes) : 32'h0;
    if (v && !bad) begin
      for (int b = 0; b < 4; b++) if (wm[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++)
      check($sformatf("lat%0d_reset", lat_of(g)), {resp_l[g], err_l[g], rdata_l[g]}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every word so the reference knows all contents.
    for (int i = 0; i < WORDS; i++) step(BASE + 32'(4 * i), 4'h0, 4'hF, $urandom, 1'b0);

    // Write then read, then a byte-lane write and a partial read.
    step(BASE, 4'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    step(BASE, 4'hF, 4'h0, 32'h0, 1'b0);
    step(BASE, 4'h0, 4'b0010, 32'h0000_5500, 1'b0);
    step(BASE, 4'b0110, 4'h0, 32'h0, 1'b0);
    step(BASE, 4'hF, 4'hF, 32'h1234_5678, 1'b0);
    step(BASE, 4'hF, 4'h0, 32'h0, 1'b0);

    // Error cases and the top-of-range boundary.
    step(BASE + 32'd6, 4'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
    step(BASE + 32'd4, 4'hF, 4'h0, 32'h0, 1'b0);
    step(BASE - 32'd4, 4'hF, 4'h0, 32'h0, 1'b0);
    step(BASE + 32'(WORDS * 4), 4'hF, 4'hF, 32'h0, 1'b0);
    step(BASE + 32'(WORDS * 4 - 4), 4'hF, 4'h0, 32'h0, 1'b0);
    idle(6);

    // Back-to-back reads of four consecutive words.
    for (int i = 0; i < 4; i++) step(BASE + 32'(16 + 4 * i), 4'hF, 4'h0, 32'h0, 1'b0);
    idle(6);

    // Three reads with flush raised alongside the third.
    step(BASE + 32'd4,  4'hF, 4'h0, 32'h0, 1'b0);
    step(BASE + 32'd8,  4'hF, 4'h0, 32'h0, 1'b0);
    step(BASE + 32'd12, 4'hF, 4'h0, 32'h0, 1'b1);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      logic [3:0] wm;
      r = $urandom_range(0, 15);
      if (r == 0)      a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
      else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 8));
      else if (r == 2) a = BASE + 32'(WORDS * 4) + 32'(4 * $urandom_range(0, 8));
      else             a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      wm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(a, 4'($urandom_range(0, 15)), wm, $urandom, ($urandom_range(0, 9) == 0));
    end
    idle(8);

    // Asynchronous reset with reads still in flight.
    step(BASE, 4'hF, 4'h0, 32'h0, 1'b0);
    step(BASE + 32'd4, 4'hF, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rmask = 4'h0; wmask = 4'h0; flush = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++)
      check($sformatf("lat%0d_async_rst", lat_of(g)), {resp_l[g], err_l[g], rdata_l[g]}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++)
        check($sformatf("lat%0d_post_rst", lat_of(g)), {resp_l[g], err_l[g], rdata_l[g]}, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
